// File: rtl/fp_mult_pack.sv
// fp_mult_pack: final stage of the fp_mult datapath.
// Packs the rounded mantissa/exponent and operand special-case flags into an
// IEEE-754 single-precision word. The stage is a registered valid/ready stage
// with a two-entry skid buffer, and it keeps a sticky exception status word.

package fp_mult_pack_pkg;
  // Rounding modes shared with the rounding stage. Only the overflow result
  // depends on the mode here.
  typedef enum logic [2:0] {
    IEEE_near = 3'd0,
    IEEE_zero = 3'd1,
    IEEE_pinf = 3'd2,
    IEEE_ninf = 3'd3,
    near_up   = 3'd4,
    away_zero = 3'd5
  } round_values;

  // Exception flag bit positions inside the 5-bit flags/status words.
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;
endpackage

module fp_mult_pack
  import fp_mult_pack_pkg::*;
#(
  parameter round_values round = IEEE_near
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [25:0] rounding_result,
  input  logic [9:0]  round_exponent,
  input  logic        sign,
  input  logic        in_nan,
  input  logic        in_invalid,
  input  logic        in_inf,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  flags,
  input  logic        clr_status,
  output logic [4:0]  status
);

  localparam logic [31:0] QNAN_WORD   = 32'h7FC00000;
  localparam logic [30:0] INF_MAG     = 31'h7F800000;
  localparam logic [30:0] MAX_MAG     = 31'h7F7FFFFF;
  localparam logic [30:0] ZERO_MAG    = 31'h00000000;

  // Overflow magnitude for a given sign under the configured rounding mode:
  // modes that round towards the infinity on that side saturate to inf,
  // the others saturate to the largest finite number.
  function automatic logic [31:0] overflow_word(input logic sgn);
    logic [31:0] w;
    w = {sgn, INF_MAG};
    case (round)
      IEEE_near: w = {sgn, INF_MAG};
      near_up:   w = {sgn, INF_MAG};
      away_zero: w = {sgn, INF_MAG};
      IEEE_zero: w = {sgn, MAX_MAG};
      IEEE_pinf: w = sgn ? {1'b1, MAX_MAG} : {1'b0, INF_MAG};
      IEEE_ninf: w = sgn ? {1'b1, INF_MAG} : {1'b0, MAX_MAG};
      default:   w = {sgn, INF_MAG};
    endcase
    return w;
  endfunction

  // Packs one transaction into {flags[4:0], word[31:0]} following the
  // special-case priority: NaN/invalid, inf, zero, overflow, underflow, normal.
  function automatic logic [36:0] pack_word(
    input logic [25:0] rr,
    input logic [9:0]  ex,
    input logic        sgn,
    input logic        nan,
    input logic        inv,
    input logic        inf,
    input logic        zero
  );
    logic [31:0] w;
    logic [4:0]  f;
    w = 32'h00000000;
    f = 5'b00000;
    if (nan || inv) begin
      w = QNAN_WORD;
      f[FLAG_INVALID] = inv;
    end else if (inf) begin
      w = {sgn, INF_MAG};
    end else if (zero) begin
      w = {sgn, ZERO_MAG};
    end else if ($signed(ex) >= $signed(10'sd255)) begin
      w = overflow_word(sgn);
      f[FLAG_OVERFLOW] = 1'b1;
      f[FLAG_INEXACT]  = 1'b1;
    end else if ($signed(ex) <= $signed(10'sd0)) begin
      // Flush to zero: denormals are not produced by this datapath.
      w = {sgn, ZERO_MAG};
      f[FLAG_UNDERFLOW] = 1'b1;
      f[FLAG_INEXACT]   = 1'b1;
    end else begin
      w = {sgn, ex[7:0], rr[22:0]};
      f[FLAG_INEXACT] = ~rr[25];
    end
    f[FLAG_DIVZERO] = 1'b0;
    return {f, w};
  endfunction

  // Bit 24 is zero after renormalisation and bit 23 is the hidden leading 1;
  // neither is stored in the packed word.
  logic unused_rr_bits_s;
  assign unused_rr_bits_s = &{1'b0, rounding_result[24:23]};

  logic [36:0] packed_s;
  logic [31:0] pack_res_s;
  logic [4:0]  pack_flg_s;

  assign packed_s   = pack_word(rounding_result, round_exponent, sign,
                                in_nan, in_invalid, in_inf, in_zero);
  assign pack_res_s = packed_s[31:0];
  assign pack_flg_s = packed_s[36:32];

  // Entry 0 is the output register, entry 1 the skid slot.
  logic        v0_r, v1_r;
  logic [31:0] res0_r, res1_r;
  logic [4:0]  flg0_r, flg1_r;
  logic [4:0]  status_r;

  logic        v0_n, v1_n;
  logic [31:0] res0_n, res1_n;
  logic [4:0]  flg0_n, flg1_n;
  logic [4:0]  status_n;

  logic        accept_s;
  logic        xfer_s;

  // in_ready comes straight from the skid-slot register, so it never depends
  // combinationally on out_ready, and it reads 1 while reset clears v1_r.
  assign in_ready  = ~v1_r;
  assign accept_s  = in_valid & ~v1_r;
  assign xfer_s    = v0_r & out_ready;

  assign out_valid = v0_r;
  assign result    = res0_r;
  assign flags     = flg0_r;
  assign status    = status_r;

  // Next-state of the two buffer entries: FIFO order, entry 0 held stable
  // while stalled, skid slot promoted into entry 0 on a transfer.
  always_comb begin
    v0_n   = v0_r;
    res0_n = res0_r;
    flg0_n = flg0_r;
    v1_n   = v1_r;
    res1_n = res1_r;
    flg1_n = flg1_r;
    if (xfer_s) begin
      if (v1_r) begin
        // Skid slot full implies no accept this cycle (in_ready was 0).
        res0_n = res1_r;
        flg0_n = flg1_r;
        v1_n   = 1'b0;
      end else if (accept_s) begin
        res0_n = pack_res_s;
        flg0_n = pack_flg_s;
      end else begin
        v0_n = 1'b0;
      end
    end else if (accept_s) begin
      if (!v0_r) begin
        v0_n   = 1'b1;
        res0_n = pack_res_s;
        flg0_n = pack_flg_s;
      end else begin
        v1_n   = 1'b1;
        res1_n = pack_res_s;
        flg1_n = pack_flg_s;
      end
    end else begin
      v0_n = v0_r;
    end
  end

  // Sticky status: a transfer ORs in its flags (after an optional clear),
  // a clear without a transfer empties the status.
  always_comb begin
    status_n = status_r;
    if (xfer_s) begin
      status_n = (clr_status ? 5'b00000 : status_r) | flg0_r;
    end else if (clr_status) begin
      status_n = 5'b00000;
    end else begin
      status_n = status_r;
    end
  end

  // State registers; reset discards both entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r     <= 1'b0;
      v1_r     <= 1'b0;
      res0_r   <= 32'h00000000;
      res1_r   <= 32'h00000000;
      flg0_r   <= 5'b00000;
      flg1_r   <= 5'b00000;
      status_r <= 5'b00000;
    end else begin
      v0_r     <= v0_n;
      v1_r     <= v1_n;
      res0_r   <= res0_n;
      res1_r   <= res1_n;
      flg0_r   <= flg0_n;
      flg1_r   <= flg1_n;
      status_r <= status_n;
    end
  end

endmodule

// File: tb/tb_fp_mult_pack.sv
// Self-checking bench for fp_mult_pack: table of directed packing vectors
// applied to a nearest-rounding and a towards-zero instance, plus hand-written
// sequences for backpressure, sticky status and asynchronous reset.
module tb_fp_mult_pack;
  import fp_mult_pack_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [25:0] rr;
  logic [9:0]  ex;
  logic        sg, nan, inv, inf, zero;
  logic        out_ready;
  logic        clr_status;

  logic        in_ready_n, out_valid_n;
  logic [31:0] result_n;
  logic [4:0]  flags_n, status_n;
  logic        in_ready_z, out_valid_z;
  logic [31:0] result_z;
  logic [4:0]  flags_z, status_z;

  int n_cmp = 0;
  int n_bad = 0;

  fp_mult_pack #(.round(IEEE_near)) dut_near (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
    .rounding_result(rr), .round_exponent(ex), .sign(sg),
    .in_nan(nan), .in_invalid(inv), .in_inf(inf), .in_zero(zero),
    .out_valid(out_valid_n), .out_ready(out_ready), .result(result_n),
    .flags(flags_n), .clr_status(clr_status), .status(status_n)
  );

  fp_mult_pack #(.round(IEEE_zero)) dut_zero (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .rounding_result(rr), .round_exponent(ex), .sign(sg),
    .in_nan(nan), .in_invalid(inv), .in_inf(inf), .in_zero(zero),
    .out_valid(out_valid_z), .out_ready(out_ready), .result(result_z),
    .flags(flags_z), .clr_status(clr_status), .status(status_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] rr;
    logic [9:0]  ex;
    logic        sg, nan, inv, inf, zero;
    logic [31:0] res_near;
    logic [31:0] res_zero;
    logic [4:0]  flg;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [25:0] r, input logic [9:0] e,
                              input logic s, input logic a, input logic b,
                              input logic c, input logic d,
                              input logic [31:0] rn, input logic [31:0] rz,
                              input logic [4:0] f);
    vec_t v;
    v.rr = r; v.ex = e; v.sg = s; v.nan = a; v.inv = b; v.inf = c; v.zero = d;
    v.res_near = rn; v.res_zero = rz; v.flg = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    rr = v.rr; ex = v.ex; sg = v.sg; nan = v.nan; inv = v.inv; inf = v.inf; zero = v.zero;
  endtask

  // One vector: present for one cycle, check the registered result a cycle
  // later, let it transfer on the following edge.
  task automatic apply_vec(input int i);
    @(negedge clk);
    check($sformatf("idle_out_valid[%0d]", i), {31'h0, out_valid_n}, 32'd0);
    drive_vec(vecs[i]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check($sformatf("out_valid[%0d]", i), {31'h0, out_valid_n}, 32'd1);
    check($sformatf("result_near[%0d]", i), result_n, vecs[i].res_near);
    check($sformatf("result_zero[%0d]", i), result_z, vecs[i].res_zero);
    check($sformatf("flags_near[%0d]", i), {27'h0, flags_n}, {27'h0, vecs[i].flg});
    check($sformatf("flags_zero[%0d]", i), {27'h0, flags_z}, {27'h0, vecs[i].flg});
  endtask

  logic [31:0] bp_exp [4];
  logic [9:0]  bp_ex  [4];
  logic [31:0] rx [$];
  int          sent;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
    rr = 26'h0; ex = 10'h0; sg = 1'b0; nan = 1'b0; inv = 1'b0; inf = 1'b0; zero = 1'b0;

    vecs[0]  = mk(26'h2C00000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3FC00000, 32'h3FC00000, 5'b00000);
    vecs[1]  = mk(26'h0C00000, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFF800000, 32'hFF7FFFFF, 5'b00101);
    vecs[2]  = mk(26'h0C00000, 10'h3F0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80000000, 32'h80000000, 5'b00011);
    vecs[3]  = mk(26'h2C00000, 10'd127, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h7FC00000, 32'h7FC00000, 5'b10000);
    vecs[4]  = mk(26'h2C00000, 10'd127, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h7FC00000, 32'h7FC00000, 5'b00000);
    vecs[5]  = mk(26'h2C00000, 10'd127, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h7F800000, 32'h7F800000, 5'b00000);
    vecs[6]  = mk(26'h2C00000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80000000, 32'h80000000, 5'b00000);
    vecs[7]  = mk(26'h0C00000, 10'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 32'h7F7FFFFF, 5'b00101);
    vecs[8]  = mk(26'h0FFFFFF, 10'd254, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'b00001);
    vecs[9]  = mk(26'h2C00000, 10'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'b00011);
    vecs[10] = mk(26'h2800000, 10'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00800000, 32'h00800000, 5'b00000);
    vecs[11] = mk(26'h2C00000, 10'd127, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7FC00000, 32'h7FC00000, 5'b00000);
    vecs[12] = mk(26'h2C00000, 10'd127, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFF800000, 32'hFF800000, 5'b00000);
    vecs[13] = mk(26'h0C00000, 10'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 5'b00011);
    vecs[14] = mk(26'h0C00000, 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 32'h7F7FFFFF, 5'b00101);
    vecs[15] = mk(26'h2FFFFFF, 10'd128, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC07FFFFF, 32'hC07FFFFF, 5'b00000);

    bp_ex[0] = 10'd100; bp_exp[0] = 32'h32000000;
    bp_ex[1] = 10'd101; bp_exp[1] = 32'h32800000;
    bp_ex[2] = 10'd102; bp_exp[2] = 32'h33000000;
    bp_ex[3] = 10'd103; bp_exp[3] = 32'h33800000;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid_n}, 32'd0);
    check("rst_in_ready",  {31'h0, in_ready_n}, 32'd1);
    check("rst_result",    result_n, 32'h00000000);
    check("rst_flags",     {27'h0, flags_n}, 32'd0);
    check("rst_status",    {27'h0, status_n}, 32'd0);
    rst_n = 1'b1;

    // Packing table.
    for (int i = 0; i < NV; i++) apply_vec(i);

    // Clear without transfer.
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("status_clear", {27'h0, status_n}, 32'd0);

    // Overflow then inexact-only accumulate.
    apply_vec(1);
    apply_vec(8);
    @(negedge clk);
    check("status_accum", {27'h0, status_n}, {27'h0, 5'b00101});

    // Clear coincident with an underflow transfer keeps only the new flags.
    drive_vec(vecs[2]);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    check("status_clr_xfer", {27'h0, status_n}, {27'h0, 5'b00011});

    // Backpressure: four back-to-back items, out_ready held low for 6 cycles.
    sent = 0;
    rx.delete();
    rr = 26'h2800000; sg = 1'b0; nan = 1'b0; inv = 1'b0; inf = 1'b0; zero = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (sent < 4) begin
        in_valid = 1'b1;
        ex = bp_ex[sent];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc >= 6);
      if (cyc == 0 || cyc == 1)
        check($sformatf("bp_in_ready_hi[%0d]", cyc), {31'h0, in_ready_n}, 32'd1);
      if (cyc == 2 || cyc == 5)
        check($sformatf("bp_in_ready_lo[%0d]", cyc), {31'h0, in_ready_n}, 32'd0);
      if (cyc == 5) begin
        check("bp_hold_valid", {31'h0, out_valid_n}, 32'd1);
        check("bp_hold_result", result_n, bp_exp[0]);
        check("bp_sent_stalled", sent, 32'd2);
      end
      if (in_valid && in_ready_n) sent++;
      if (out_valid_n && out_ready) rx.push_back(result_n);
    end
    in_valid = 1'b0;
    check("bp_count", rx.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx.size()) check($sformatf("bp_order[%0d]", i), rx[i], bp_exp[i]);
      else check($sformatf("bp_order[%0d]", i), 32'hDEADDEAD, bp_exp[i]);
    end

    // Async reset with both entries full.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ex = bp_ex[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_pre_in_ready", {31'h0, in_ready_n}, 32'd0);
    check("ar_pre_status", {27'h0, status_n}, {27'h0, 5'b00011});
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'h0, out_valid_n}, 32'd0);
    check("ar_in_ready",  {31'h0, in_ready_n}, 32'd1);
    check("ar_status",    {27'h0, status_n}, 32'd0);
    check("ar_result",    result_n, 32'h00000000);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ar_post_out_valid", {31'h0, out_valid_n}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
